muldiv_issue_seq: RTL and testbench

MULDIV_ISSUE_SEQ -- requirements
Module: muldiv_issue_seq

---
 rtl/muldiv_issue_seq_if.sv | 33 +++
 rtl/muldiv_issue_seq.sv | 110 +++++++++++
 tb/tb_muldiv_issue_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_seq_if.sv
// rtl/muldiv_issue_seq_if.sv - issue, dealloc, datapath and writeback signals of the mul/div issue sequencer
interface muldiv_issue_seq_if #(
    parameter int AGE_WIDTH  = 5,
    parameter int PTAG_WIDTH = 6
);
    logic                  issue_grant;
    logic [3:0]            issue_addr;
    logic                  issue_is_div;
    logic [AGE_WIDTH-1:0]  issue_age;
    logic [PTAG_WIDTH-1:0] issue_ptag;
    logic                  flush;
    logic                  muti_finish;
    logic                  iq_dealloc_valid;
    logic [3:0]            iq_dealloc_addr;
    logic                  unit_start;
    logic                  unit_is_div;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [PTAG_WIDTH-1:0] wb_ptag;
    logic [AGE_WIDTH-1:0]  wb_age;

    modport master (
        output issue_grant, issue_addr, issue_is_div, issue_age, issue_ptag, flush, wb_ready,
        input  muti_finish, iq_dealloc_valid, iq_dealloc_addr, unit_start, unit_is_div,
               wb_valid, wb_ptag, wb_age
    );

    modport slave (
        input  issue_grant, issue_addr, issue_is_div, issue_age, issue_ptag, flush, wb_ready,
        output muti_finish, iq_dealloc_valid, iq_dealloc_addr, unit_start, unit_is_div,
               wb_valid, wb_ptag, wb_age
    );
endinterface

// File: rtl/muldiv_issue_seq.sv
// rtl/muldiv_issue_seq.sv - single-op sequencer for the multi-cycle mul/div unit
module muldiv_issue_seq #(
    parameter int AGE_WIDTH  = 5,
    parameter int PTAG_WIDTH = 6,
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 34
) (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_issue_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    state_t                state;
    logic [5:0]            cnt;
    logic [3:0]            cap_addr;
    logic                  cap_div;
    logic [AGE_WIDTH-1:0]  cap_age;
    logic [PTAG_WIDTH-1:0] cap_ptag;

    logic                  fin_q;
    logic                  start_q;
    logic                  dv_q;
    logic [3:0]            da_q;
    logic                  div_q;
    logic                  wbv_q;
    logic [PTAG_WIDTH-1:0] wbp_q;
    logic [AGE_WIDTH-1:0]  wba_q;

    // Outputs are registered alongside the state so they describe the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_div  <= 1'b0;
            cap_age  <= '0;
            cap_ptag <= '0;
            fin_q    <= 1'b1;
            start_q  <= 1'b0;
            dv_q     <= 1'b0;
            da_q     <= '0;
            div_q    <= 1'b0;
            wbv_q    <= 1'b0;
            wbp_q    <= '0;
            wba_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.issue_grant) begin
                        state    <= START;
                        cap_addr <= bus.issue_addr;
                        cap_div  <= bus.issue_is_div;
                        cap_age  <= bus.issue_age;
                        cap_ptag <= bus.issue_ptag;
                        fin_q    <= 1'b0;
                        start_q  <= 1'b1;
                        dv_q     <= 1'b1;
                        da_q     <= bus.issue_addr;
                        div_q    <= bus.issue_is_div;
                    end
                end
                START: begin
                    state   <= BUSY;
                    cnt     <= cap_div ? DIV_LOAD : MUL_LOAD;
                    start_q <= 1'b0;
                    dv_q    <= 1'b0;
                    da_q    <= '0;
                end
                BUSY: begin
                    if (cnt == 6'd0) begin
                        state <= DONE;
                        wbv_q <= 1'b1;
                        wbp_q <= cap_ptag;
                        wba_q <= cap_age;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DONE: begin
                    if (bus.wb_ready) begin
                        state    <= IDLE;
                        cap_addr <= '0;
                        cap_div  <= 1'b0;
                        cap_age  <= '0;
                        cap_ptag <= '0;
                        fin_q    <= 1'b1;
                        div_q    <= 1'b0;
                        wbv_q    <= 1'b0;
                        wbp_q    <= '0;
                        wba_q    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.muti_finish      = fin_q;
    assign bus.unit_start       = start_q;
    assign bus.iq_dealloc_valid = dv_q;
    assign bus.iq_dealloc_addr  = da_q;
    assign bus.unit_is_div      = div_q;
    assign bus.wb_valid         = wbv_q;
    assign bus.wb_ptag          = wbp_q;
    assign bus.wb_age           = wba_q;
endmodule

// File: tb/tb_muldiv_issue_seq.sv
// tb/tb_muldiv_issue_seq.sv - vector table, corner sequences and random model checks for muldiv_issue_seq
module tb_muldiv_issue_seq;
    localparam int AW  = 5;
    localparam int PW  = 6;
    localparam int ML  = 3;
    localparam int DL  = 34;
    localparam int OBW = 9 + PW + AW;

    typedef logic [OBW-1:0] obs_t;

    typedef struct {
        logic          g;
        logic [3:0]    a;
        logic          d;
        logic [AW-1:0] ag;
        logic [PW-1:0] p;
        logic          fl;
        logic          wr;
        obs_t          e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_issue_seq_if #(.AGE_WIDTH(AW), .PTAG_WIDTH(PW)) bus ();

    muldiv_issue_seq #(
        .AGE_WIDTH(AW), .PTAG_WIDTH(PW), .MUL_LAT(ML), .DIV_LAT(DL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic obs_t pack(logic fin, logic us, logic dv, logic [3:0] da, logic id,
                                  logic wbv, logic [PW-1:0] wp, logic [AW-1:0] wa);
        return {fin, us, dv, da, id, wbv, wp, wa};
    endfunction

    function automatic obs_t observe();
        return {bus.muti_finish, bus.unit_start, bus.iq_dealloc_valid, bus.iq_dealloc_addr,
                bus.unit_is_div, bus.wb_valid, bus.wb_ptag, bus.wb_age};
    endfunction

    function automatic vec_t mkv(logic g, logic [3:0] a, logic d, logic [AW-1:0] ag,
                                 logic [PW-1:0] p, logic fl, logic wr, obs_t e);
        vec_t v;
        v.g = g; v.a = a; v.d = d; v.ag = ag; v.p = p; v.fl = fl; v.wr = wr; v.e = e;
        return v;
    endfunction

    task automatic check(string name, obs_t exp);
        obs_t act;
        act = observe();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got fin/start/dv/daddr/div/wbv/ptag/age=%h expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic drive(logic g, logic [3:0] a, logic d, logic [AW-1:0] ag,
                         logic [PW-1:0] p, logic fl, logic wr);
        bus.issue_grant  = g;
        bus.issue_addr   = a;
        bus.issue_is_div = d;
        bus.issue_age    = ag;
        bus.issue_ptag   = p;
        bus.flush        = fl;
        bus.wb_ready     = wr;
    endtask

    // Transaction-level reference: an op is either absent or some number of cycles past its grant.
    bit            m_act;
    int            m_el;
    int            m_lat;
    logic          m_div;
    logic [3:0]    m_a;
    logic [AW-1:0] m_ag;
    logic [PW-1:0] m_p;

    function automatic obs_t model_exp();
        if (!m_act)             return pack(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0, '0);
        if (m_el == 1)          return pack(1'b0, 1'b1, 1'b1, m_a, m_div, 1'b0, '0, '0);
        if (m_el <= m_lat + 1)  return pack(1'b0, 1'b0, 1'b0, 4'd0, m_div, 1'b0, '0, '0);
        return pack(1'b0, 1'b0, 1'b0, 4'd0, m_div, 1'b1, m_p, m_ag);
    endfunction

    task automatic model_step();
        if (!rst_n || bus.flush) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (bus.issue_grant) begin
                m_act = 1'b1;
                m_el  = 1;
                m_div = bus.issue_is_div;
                m_a   = bus.issue_addr;
                m_ag  = bus.issue_age;
                m_p   = bus.issue_ptag;
                m_lat = bus.issue_is_div ? DL : ML;
            end
        end else if (m_el >= m_lat + 2) begin
            if (bus.wb_ready) m_act = 1'b0;
        end else begin
            m_el++;
        end
    endtask

    obs_t idle_o, start5, start2, busy_m, done_a, done_b;
    vec_t tbl[19];

    initial begin
        idle_o = pack(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 5'd0);
        start5 = pack(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 6'd0, 5'd0);
        start2 = pack(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 6'd0, 5'd0);
        busy_m = pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0, 5'd0);
        done_a = pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 6'd12, 5'd3);
        done_b = pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 6'd40, 5'd1);

        tbl[0]  = mkv(1'b1, 4'd5, 1'b0, 5'd3, 6'd12, 1'b0, 1'b0, idle_o);
        tbl[1]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, start5);
        tbl[2]  = mkv(1'b1, 4'd9, 1'b1, 5'd7, 6'd33, 1'b0, 1'b0, busy_m);
        tbl[3]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, busy_m);
        tbl[4]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, busy_m);
        tbl[5]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, done_a);
        tbl[6]  = mkv(1'b1, 4'd3, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, done_a);
        tbl[7]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, done_a);
        tbl[8]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, done_a);
        tbl[9]  = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, done_a);
        tbl[10] = mkv(1'b1, 4'd7, 1'b1, 5'd2, 6'd5,  1'b1, 1'b0, idle_o);
        tbl[11] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, idle_o);
        tbl[12] = mkv(1'b1, 4'd2, 1'b0, 5'd1, 6'd40, 1'b0, 1'b0, idle_o);
        tbl[13] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b0, start2);
        tbl[14] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, busy_m);
        tbl[15] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, busy_m);
        tbl[16] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, busy_m);
        tbl[17] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, done_b);
        tbl[18] = mkv(1'b0, 4'd0, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, idle_o);

        rst_n = 1'b0;
        drive(1'b1, 4'd15, 1'b1, 5'd31, 6'd63, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("reset_state", idle_o);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("after_reset", idle_o);

        foreach (tbl[i]) begin
            check($sformatf("table_row%0d", i), tbl[i].e);
            drive(tbl[i].g, tbl[i].a, tbl[i].d, tbl[i].ag, tbl[i].p, tbl[i].fl, tbl[i].wr);
            @(negedge clk);
        end

        // Divide: unit_is_div held from START through DONE, result DL+2 cycles after grant.
        drive(1'b1, 4'd3, 1'b1, 5'd2, 6'd7, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        for (int c = 1; c <= DL + 3; c++) begin
            if (c == DL + 3)
                check("div_idle", idle_o);
            else
                check($sformatf("div_c%0d", c),
                      pack(1'b0, c == 1, c == 1, (c == 1) ? 4'd3 : 4'd0, 1'b1, c == DL + 2,
                           (c == DL + 2) ? 6'd7 : 6'd0, (c == DL + 2) ? 5'd2 : 5'd0));
            @(negedge clk);
        end

        // Flush mid-divide, then an immediate new multiply.
        drive(1'b1, 4'd6, 1'b1, 5'd4, 6'd9, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("flushdiv_c%0d", c),
                  pack(1'b0, c == 1, c == 1, (c == 1) ? 4'd6 : 4'd0, 1'b1, 1'b0, 6'd0, 5'd0));
            if (c == 10) drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
            @(negedge clk);
        end
        check("flush_idle", idle_o);
        drive(1'b1, 4'd4, 1'b0, 5'd6, 6'd11, 1'b0, 1'b1);
        @(negedge clk);
        check("regrant_start", pack(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 6'd0, 5'd0));
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        for (int c = 0; c < ML; c++) begin
            @(negedge clk);
            check("regrant_busy", busy_m);
        end
        @(negedge clk);
        check("regrant_done", pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 6'd11, 5'd6));
        @(negedge clk);
        check("regrant_idle", idle_o);

        // Flush in START: START outputs still seen, nothing afterwards.
        drive(1'b1, 4'd8, 1'b0, 5'd1, 6'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("fstart_start", pack(1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 6'd0, 5'd0));
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            check("fstart_idle", idle_o);
            @(negedge clk);
        end

        // Flush together with wb_ready in DONE.
        drive(1'b1, 4'd1, 1'b0, 5'd5, 6'd20, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        repeat (ML + 1) @(negedge clk);
        check("fdone_done", pack(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 6'd20, 5'd5));
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("fdone_idle", idle_o);

        // Reset in the middle of a divide.
        drive(1'b1, 4'd10, 1'b1, 5'd9, 6'd30, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstbusy_idle", idle_o);
        rst_n = 1'b1;
        for (int c = 0; c < DL + 6; c++) begin
            @(negedge clk);
            check("rstbusy_quiet", idle_o);
        end

        // Random traffic against the reference model.
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_act = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            check("random", model_exp());
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 1) == 1,
                  AW'($urandom), PW'($urandom), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) < 3);
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
